// File: rtl/max_int16_stream.sv
// Streaming signed max/argmax reducer over valid/ready element sets.
// Optional MAX_STREAM_TIE_LAST_EN: equal values move the index to the latest occurrence.

module gt_int_nbit #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  generate
    if (IMPL_TYPE == 1) begin : g_bias
      // Flipping the sign bit maps two's-complement order onto unsigned order.
      assign gt = {~a[WIDTH-1], a[WIDTH-2:0]} > {~b[WIDTH-1], b[WIDTH-2:0]};
    end else if (IMPL_TYPE == 2) begin : g_sub
      logic [WIDTH:0] diff;
      assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      assign gt   = ~diff[WIDTH] && (diff != '0);
    end else begin : g_direct
      assign gt = $signed(a) > $signed(b);
    end
  endgenerate
endmodule

module max_int16_stream #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] max_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] cnt_r;
  logic             ovf_r;
  logic             first_r;
  logic             is_gt;
  logic             upd;
  logic             accept;
  logic             release_hs;

  gt_int_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_gt (
    .a  (in_data),
    .b  (max_r),
    .gt (is_gt)
  );

  assign accept     = in_valid && in_ready;
  assign release_hs = out_valid && out_ready;

`ifdef MAX_STREAM_TIE_LAST_EN
  assign upd = first_r || is_gt || (in_data == max_r);
`else
  assign upd = first_r || is_gt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (release_hs)        state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // in_ready stays low while reset is asserted, otherwise it is purely state-decoded.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = rst_n;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_r   <= '0;
      idx_r   <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      first_r <= 1'b1;
    end else if (accept) begin
      first_r <= 1'b0;
      cnt_r   <= cnt_r + IDX_W'(1);
      if (cnt_r == '1) ovf_r <= 1'b1;
      if (upd) begin
        max_r <= in_data;
        idx_r <= first_r ? '0 : cnt_r;
      end
    end else if (release_hs) begin
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      first_r <= 1'b1;
    end
  end

  assign out_max   = max_r;
  assign out_idx   = idx_r;
  assign out_count = cnt_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_max_int16_stream.sv
module tb_max_int16_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_max;
  logic [7:0]  out_idx;
  logic [7:0]  out_count;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

`ifdef MAX_STREAM_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic [15:0] stim[$];
  logic [15:0] o_max;
  logic [7:0]  o_idx, o_cnt;
  logic        o_ovf, o_lat;
  logic [15:0] e_max;
  logic [7:0]  e_idx, e_cnt;
  logic        e_ovf;

  max_int16_stream #(.WIDTH(16), .IDX_W(8), .IMPL_TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: signed max with first (or last, for ties) occurrence, wrapped count.
  function automatic void model(output logic [15:0] m, output logic [7:0] ix,
                                output logic [7:0] cnt, output logic ov);
    int best, bi, v;
    best = int'($signed(stim[0]));
    bi   = 0;
    for (int i = 1; i < stim.size(); i++) begin
      v = int'($signed(stim[i]));
      if (v > best || (TIE_LAST && v == best)) begin
        best = v;
        bi   = i;
      end
    end
    m   = best[15:0];
    ix  = 8'(bi % 256);
    cnt = 8'(stim.size() % 256);
    ov  = stim.size() > 255;
  endfunction

  // Drives stim as one set; returns the outputs seen just after the last accept edge.
  task automatic run_set(input int idle_pct);
    logic pre;
    pre = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      for (int k = 0; k < 3 && $urandom_range(0, 99) < idle_pct; k++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = (i == stim.size() - 1);
      if (i == stim.size() - 1) pre = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    o_lat = !pre && out_valid;
    o_max = out_max;
    o_idx = out_idx;
    o_cnt = out_count;
    o_ovf = out_ovf;
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({out_valid, out_max, out_idx, out_count, out_ovf} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h %h %h %h %b want zeros", out_valid, out_max, out_idx, out_count, out_ovf);
    end
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_high got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    stim = '{16'd5, 16'hFFFD, 16'd12, 16'd7};
    out_ready = 1'b1;
    run_set(0);
    checks++; if ({o_max, o_idx, o_cnt, o_ovf} !== {16'd12, 8'd2, 8'd4, 1'b0}) begin
      errors++; $display("FAIL basic got max=%h idx=%0d cnt=%0d ovf=%b want 000c 2 4 0", o_max, o_idx, o_cnt, o_ovf);
    end
    checks++; if (o_lat !== 1'b1) begin
      errors++; $display("FAIL basic_latency got %b want 1", o_lat);
    end
    drain(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL basic_rearm got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_signed();
    bit ok;
    stim = '{16'h8000, 16'hFFFF, 16'h8001};
    run_set(0);
    checks++; if ({o_max, o_idx, o_cnt} !== {16'hFFFF, 8'd1, 8'd3}) begin
      errors++; $display("FAIL signed got max=%h idx=%0d cnt=%0d want ffff 1 3", o_max, o_idx, o_cnt);
    end
    drain(ok);
  endtask

  task automatic test_ties();
    bit ok;
    logic [7:0] want_idx;
    want_idx = TIE_LAST ? 8'd3 : 8'd0;
    stim = '{16'd9, 16'd9, 16'd4, 16'd9};
    run_set(0);
    checks++; if ({o_max, o_idx} !== {16'd9, want_idx}) begin
      errors++; $display("FAIL ties got max=%0d idx=%0d want 9 %0d", o_max, o_idx, want_idx);
    end
    drain(ok);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [33:0] snap;
    int bad;
    bad = 0;
    out_ready = 1'b0;
    stim = '{16'd1};
    run_set(0);
    snap = {out_max, out_idx, out_count, out_ovf, out_valid};
    checks++; if ({o_max, o_idx, o_cnt} !== {16'd1, 8'd0, 8'd1}) begin
      errors++; $display("FAIL bp_single got max=%h idx=%0d cnt=%0d want 0001 0 1", o_max, o_idx, o_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {out_max, out_idx, out_count, out_ovf, out_valid} !== snap) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
    end
    drain(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    stim = '{16'hFFFE};
    run_set(0);
    checks++; if ({o_max, o_idx, o_cnt, o_ovf} !== {16'hFFFE, 8'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL bp_next got max=%h idx=%0d cnt=%0d ovf=%b want fffe 0 1 0", o_max, o_idx, o_cnt, o_ovf);
    end
    drain(ok);
  endtask

  task automatic test_overflow();
    bit ok;
    stim.delete();
    for (int i = 0; i < 257; i++) stim.push_back(i == 3 ? 16'd100 : 16'd0);
    run_set(0);
    checks++; if ({o_max, o_idx, o_cnt, o_ovf} !== {16'd100, 8'd3, 8'd1, 1'b1}) begin
      errors++; $display("FAIL overflow got max=%0d idx=%0d cnt=%0d ovf=%b want 100 3 1 1", o_max, o_idx, o_cnt, o_ovf);
    end
    drain(ok);
    checks++; if (out_ovf !== 1'b0 || out_count !== 8'd0) begin
      errors++; $display("FAIL overflow_clear got ovf=%b cnt=%0d want 0 0", out_ovf, out_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    in_valid = 1'b1; in_data = 16'd50; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 16'd60;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if ({out_valid, out_max, out_idx, out_count, out_ovf} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got %b %h %h %h %b want zeros", out_valid, out_max, out_idx, out_count, out_ovf);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    stim = '{16'd3};
    run_set(0);
    checks++; if ({o_max, o_idx, o_cnt, o_ovf} !== {16'd3, 8'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL rst_mid_next got max=%h idx=%0d cnt=%0d ovf=%b want 0003 0 1 0", o_max, o_idx, o_cnt, o_ovf);
    end
    drain(ok);
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] pool[5];
    int n, hold, bad;
    pool = '{16'hFFFF, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
    for (int s = 0; s < 30; s++) begin
      stim.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        stim.push_back($urandom_range(0, 1) ? 16'($urandom) : pool[$urandom_range(0, 4)]);
      out_ready = 1'b0;
      run_set(30);
      model(e_max, e_idx, e_cnt, e_ovf);
      checks++; if ({o_max, o_idx, o_cnt, o_ovf, o_lat} !== {e_max, e_idx, e_cnt, e_ovf, 1'b1}) begin
        errors++; $display("FAIL random_set%0d got max=%h idx=%0d cnt=%0d ovf=%b lat=%b want %h %0d %0d %b 1",
                           s, o_max, o_idx, o_cnt, o_ovf, o_lat, e_max, e_idx, e_cnt, e_ovf);
      end
      hold = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_max !== e_max || out_idx !== e_idx) bad++;
      end
      checks++; if (bad != 0) begin
        errors++; $display("FAIL random_hold%0d got %0d unstable cycles want 0", s, bad);
      end
      drain(ok);
      checks++; if (!ok) begin
        errors++; $display("FAIL random_rearm%0d got in_ready=%b want 1", s, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_ties();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
